cordic_nco_scheduler: RTL and testbench
=======================================

// Module: cordic_nco_scheduler
// PURPOSE
//  Multi-channel NCO front end that time-shares one cordic_phase pipeline. Holds a phase
//  accumulator and increment per channel. Issues one phase word per cycle, round-robin over
//  the enabled channels, and tags each issue with valid/channel through a delay line matched
//  to the CORDIC latency, so results come out labelled. Sits between the config/register bus
//  and the CORDIC; feeds downstream mixers.
// PARAMETERS
//  NUM_CH   4   channel count (2..16)
//  CH_W     2   channel index width, = clog2(NUM_CH)
//  LATENCY  15  CORDIC edges from arg sampled to Re_out/Im_out valid
//  PH_W     19  accumulator width; one full turn = 2^19 (quadrant = acc[18:17])
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous reset, active-high
//  cfg_we       in   1      write strobe for channel cfg_ch
//  cfg_ch       in   CH_W   channel addressed by cfg_we
//  cfg_inc      in   PH_W   phase increment, written when cfg_we=1
//  cfg_load     in   1      with cfg_we: also load accumulator with cfg_phase
//  cfg_phase    in   PH_W   accumulator load value
//  ch_en        in   NUM_CH per-channel enable, bit i = channel i
//  hold         in   1      1 = issue nothing this cycle; accumulators frozen
//  sync         in   1      zero all accumulators, rr pointer -> 0
//  cordic_arg   out  20     to CORDIC arg: {1'b0, acc}, registered
//  cordic_re    in   16     from CORDIC Re_out
//  cordic_im    in   16     from CORDIC Im_out
//  out_valid    out  1      cordic_re/im hold a scheduled sample
//  out_ch       out  CH_W   channel owning that sample
//  out_re       out  16     = cordic_re (passthrough, aligned with out_valid)
//  out_im       out  16     = cordic_im
// BEHAVIOUR
//  Reset: acc[]=0, inc[]=0, rr_ptr=0, cordic_arg=0, delay line cleared, out_valid=0, out_ch=0.
//  Reset mid-run drops all in-flight samples: out_valid=0 from the edge after rst is sampled.
//  Issue select, each cycle:
//   - Find the first channel c with ch_en[c]=1, scanning rr_ptr, rr_ptr+1 .. mod NUM_CH.
//   - If one is found and hold=0 and sync=0: cordic_arg<={1'b0,acc[c]},
//     acc[c]<=acc[c]+inc[c] (mod 2^PH_W), rr_ptr<=c+1 mod NUM_CH, iss_vld<=1, iss_ch<=c.
//   - Otherwise iss_vld<=0 and cordic_arg keeps its value.
//  Tag pipe: iss_vld/iss_ch register with cordic_arg, then pass through LATENCY stages.
//   - out_valid/out_ch are the last stage.
//   - A sample issued at edge E appears at edge E+1+LATENCY = 16 edges with defaults.
//   - The delay line never stalls. There is no backpressure; consumers must accept every valid.
//  Config:
//   - cfg_we writes inc[cfg_ch]. With cfg_load=1 it also sets acc[cfg_ch]=cfg_phase.
//   - Config wins over issue-advance on the same channel in the same cycle; the issued arg is
//     the old acc.
//   - cfg_ch >= NUM_CH is ignored.
//  sync:
//   - Beats cfg_load. All acc=0 and rr_ptr=0 next cycle; no issue that cycle.
//   - In-flight tags still drain.
//  ch_en:
//   - Sampled each cycle. Dropping a bit stops new issues only; in-flight samples still emerge.
//   - ch_en=0 gives zero issues. A single enabled channel issues every cycle.
//  Width: acc and inc are unsigned PH_W. Overflow wraps (one turn). cordic_arg[19] is always 0.
// TESTING
//  T1 NUM_CH=4, ch_en=0001, inc0=0x20000, after rst:
//     - args 0,0x20000,0x40000,0x60000,0.
//     - out (re,im) ~ (32767,0),(0,32767),(-32767,0),(0,-32767) within +/-8 LSB.
//     - First out_valid 16 edges after first issue.
//  T2 ch_en=0011:
//     - out_ch alternates 0,1,0,1 with out_valid continuously 1.
//     - Each channel's acc advances once per 2 cycles.
//  T3 ch_en=1010: out_ch sequence 1,3,1,3. Then ch_en->0000: out_valid falls exactly 16 edges
//     after the last issue.
//  T4 cfg_we+cfg_load on ch0 (cfg_phase=0x10000) in the same cycle ch0 issues:
//     - That issue's arg = old acc.
//     - The next ch0 arg = 0x10000.
//  T5 sync pulse mid-run: one bubble (out_valid=0 slot 16 edges later), then ch0 restarts at
//     arg 0. hold=1 for 3 cycles gives a 3-sample gap and no acc advance.
//  T6 rst asserted with 10 samples in flight: out_valid=0 from the next edge. After release,
//     the first valid arrives 16 edges after the first issue, with arg 0.

Source files
------------

// File: rtl/cordic_nco_scheduler.sv
// ---------------------------------------------------------------------------
// cordic_nco_scheduler
//
// Multi-channel NCO front end that time-shares a single CORDIC phase
// pipeline. Each channel has its own phase accumulator and increment. Every
// cycle the scheduler picks one enabled channel round-robin and issues that
// channel's phase word to the CORDIC. A valid/channel tag travels through a
// delay line that matches the CORDIC latency, so each result leaves labelled
// with the channel it belongs to.
//
// Ports
//   i_clk, i_rst      clock and synchronous active-high reset
//   i_cfg_we          write strobe: inc[i_cfg_ch] <= i_cfg_inc
//   i_cfg_ch          channel addressed by the config write
//   i_cfg_inc         phase increment value
//   i_cfg_load        with i_cfg_we, also load acc[i_cfg_ch] <= i_cfg_phase
//   i_cfg_phase       accumulator load value
//   i_ch_en           per-channel enable, bit i = channel i
//   i_hold            freeze: no issue, accumulators unchanged
//   i_sync            clear every accumulator and the round-robin pointer
//   o_cordic_arg      registered phase word to the CORDIC, {1'b0, acc}
//   i_cordic_re/im    CORDIC results
//   o_out_valid       the current CORDIC result belongs to a scheduled issue
//   o_out_ch          channel owning that result
//   o_out_re/im       CORDIC results passed through, aligned with the tag
// ---------------------------------------------------------------------------
module cordic_nco_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int LATENCY = 15,
    parameter int PH_W    = 19
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cfg_we,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [PH_W-1:0]   i_cfg_inc,
    input  logic              i_cfg_load,
    input  logic [PH_W-1:0]   i_cfg_phase,
    input  logic [NUM_CH-1:0] i_ch_en,
    input  logic              i_hold,
    input  logic              i_sync,
    output logic [PH_W:0]     o_cordic_arg,
    input  logic [15:0]       i_cordic_re,
    input  logic [15:0]       i_cordic_im,
    output logic              o_out_valid,
    output logic [CH_W-1:0]   o_out_ch,
    output logic [15:0]       o_out_re,
    output logic [15:0]       o_out_im
);

    logic [PH_W-1:0] r_acc [0:NUM_CH-1];
    logic [PH_W-1:0] r_inc [0:NUM_CH-1];
    logic [CH_W-1:0] r_rr_ptr;
    logic [PH_W:0]   r_cordic_arg;
    logic            r_iss_vld;
    logic [CH_W-1:0] r_iss_ch;

    // Tag stage k is loaded 1+k edges after the issue edge; the CORDIC
    // samples the registered arg one edge after issue and then needs LATENCY
    // more edges, so the last stage (index LATENCY) lines up with its result.
    logic [LATENCY:0] r_tag_vld;
    logic [CH_W-1:0]  r_tag_ch [0:LATENCY];

    logic            w_found;
    logic [CH_W-1:0] w_sel;
    logic [CH_W:0]   w_scan;
    logic            w_issue;
    logic [CH_W-1:0] w_next_ptr;

    // Round-robin search: first enabled channel starting at r_rr_ptr,
    // wrapping modulo NUM_CH. The extra bit in w_scan holds the sum before
    // the wrap so non-power-of-two channel counts work too.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_scan  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (CH_W+1)'(k);
            if (w_scan >= (CH_W+1)'(NUM_CH)) begin
                w_scan = w_scan - (CH_W+1)'(NUM_CH);
            end
            if (!w_found && i_ch_en[w_scan[CH_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_scan[CH_W-1:0];
            end
        end
    end

    assign w_issue    = w_found && !i_hold && !i_sync;
    assign w_next_ptr = (w_sel == CH_W'(NUM_CH - 1)) ? '0 : w_sel + 1'b1;

    // Issue, accumulator and config state. Priority per accumulator is
    // sync, then config load, then issue advance; the issued arg always
    // reflects the accumulator value before this edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
                r_inc[i] <= '0;
            end
            r_rr_ptr     <= '0;
            r_cordic_arg <= '0;
            r_iss_vld    <= 1'b0;
            r_iss_ch     <= '0;
        end else begin
            r_iss_vld <= w_issue;
            if (w_issue) begin
                r_cordic_arg <= {1'b0, r_acc[w_sel]};
                r_iss_ch     <= w_sel;
                r_rr_ptr     <= w_next_ptr;
            end
            if (i_sync) begin
                r_rr_ptr <= '0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (i_cfg_we && i_cfg_ch == CH_W'(i)) begin
                    r_inc[i] <= i_cfg_inc;
                end
                if (i_sync) begin
                    r_acc[i] <= '0;
                end else if (i_cfg_we && i_cfg_load && i_cfg_ch == CH_W'(i)) begin
                    r_acc[i] <= i_cfg_phase;
                end else if (w_issue && w_sel == CH_W'(i)) begin
                    r_acc[i] <= r_acc[i] + r_inc[i];
                end
            end
        end
    end

    // Tag delay line; never stalls, cleared by reset so in-flight samples
    // are dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tag_vld <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                r_tag_ch[k] <= '0;
            end
        end else begin
            r_tag_vld   <= {r_tag_vld[LATENCY-1:0], r_iss_vld};
            r_tag_ch[0] <= r_iss_ch;
            for (int k = 1; k <= LATENCY; k++) begin
                r_tag_ch[k] <= r_tag_ch[k-1];
            end
        end
    end

    assign o_cordic_arg = r_cordic_arg;
    assign o_out_valid  = r_tag_vld[LATENCY];
    assign o_out_ch     = r_tag_ch[LATENCY];
    assign o_out_re     = i_cordic_re;
    assign o_out_im     = i_cordic_im;

endmodule

// File: tb/tb_cordic_nco_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cordic_nco_scheduler
//
// Directed bench for cordic_nco_scheduler. A stand-in CORDIC samples the
// registered arg and returns it 16 edges after issue, encoded as
// re = arg[19:4], im = arg[15:0], so each labelled output can be traced back
// to the phase word that produced it. Every step states the issue expected at
// that edge (valid, channel, arg); a 16-entry ring remembers those so the
// tagged outputs can be checked when they emerge.
// ---------------------------------------------------------------------------
module tb_cordic_nco_scheduler;

    localparam int NUM_CH  = 4;
    localparam int CH_W    = 2;
    localparam int LATENCY = 15;
    localparam int PH_W    = 19;
    localparam int DLY     = LATENCY + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfgWe;
    logic [CH_W-1:0]   cfgCh;
    logic [PH_W-1:0]   cfgInc;
    logic              cfgLoad;
    logic [PH_W-1:0]   cfgPhase;
    logic [NUM_CH-1:0] chEn;
    logic              hold;
    logic              syncIn;
    logic [PH_W:0]     cordicArg;
    logic [15:0]       cordicRe;
    logic [15:0]       cordicIm;
    logic              outValid;
    logic [CH_W-1:0]   outCh;
    logic [15:0]       outRe;
    logic [15:0]       outIm;

    int errors = 0;
    int checks = 0;
    int stepNo = 0;

    logic            hVld [0:DLY-1];
    logic [CH_W-1:0] hCh  [0:DLY-1];
    logic [PH_W:0]   hArg [0:DLY-1];
    int              hPtr = 0;

    logic [PH_W:0] mockPipe [0:DLY-1];

    cordic_nco_scheduler #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .LATENCY(LATENCY),
        .PH_W   (PH_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cfg_we    (cfgWe),
        .i_cfg_ch    (cfgCh),
        .i_cfg_inc   (cfgInc),
        .i_cfg_load  (cfgLoad),
        .i_cfg_phase (cfgPhase),
        .i_ch_en     (chEn),
        .i_hold      (hold),
        .i_sync      (syncIn),
        .o_cordic_arg(cordicArg),
        .i_cordic_re (cordicRe),
        .i_cordic_im (cordicIm),
        .o_out_valid (outValid),
        .o_out_ch    (outCh),
        .o_out_re    (outRe),
        .o_out_im    (outIm)
    );

    always #5 clk = ~clk;

    // Stand-in CORDIC: arg captured one edge after issue, result after
    // LATENCY further edges.
    always @(posedge clk) begin
        mockPipe[0] <= cordicArg;
        for (int k = 1; k < DLY; k++) begin
            mockPipe[k] <= mockPipe[k-1];
        end
    end
    assign cordicRe = mockPipe[DLY-1][19:4];
    assign cordicIm = mockPipe[DLY-1][15:0];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s step=%0d observed=0x%0h expected=0x%0h", tag, stepNo, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstV, input logic [NUM_CH-1:0] enV, input logic holdV,
                                 input logic syncV, input logic weV, input logic [CH_W-1:0] chV,
                                 input logic [PH_W-1:0] incV, input logic loadV, input logic [PH_W-1:0] phaseV);
        rst      = rstV;
        chEn     = enV;
        hold     = holdV;
        syncIn   = syncV;
        cfgWe    = weV;
        cfgCh    = chV;
        cfgInc   = incV;
        cfgLoad  = loadV;
        cfgPhase = phaseV;
    endtask

    // One clock edge: check the arg issued at this edge, then check the
    // tagged output against what was issued DLY edges earlier.
    task automatic tick(input logic expVld, input logic [CH_W-1:0] expCh, input logic [PH_W:0] expArg);
        logic            rstNow;
        logic            oldVld;
        logic [CH_W-1:0] oldCh;
        logic [PH_W:0]   oldArg;
        rstNow = rst;
        @(posedge clk);
        #1;
        stepNo++;
        checkOutput("cordic_arg", 32'(cordicArg), 32'(expArg));
        if (rstNow) begin
            for (int k = 0; k < DLY; k++) begin
                hVld[k] = 1'b0;
                hCh[k]  = '0;
                hArg[k] = '0;
            end
            checkOutput("out_ch_reset", 32'(outCh), 32'd0);
        end
        oldVld = hVld[hPtr];
        oldCh  = hCh[hPtr];
        oldArg = hArg[hPtr];
        checkOutput("out_valid", 32'(outValid), 32'(oldVld));
        if (oldVld) begin
            checkOutput("out_ch", 32'(outCh), 32'(oldCh));
            checkOutput("out_re", 32'(outRe), 32'(oldArg[19:4]));
            checkOutput("out_im", 32'(outIm), 32'(oldArg[15:0]));
        end
        hVld[hPtr] = expVld;
        hCh[hPtr]  = expCh;
        hArg[hPtr] = expArg;
        hPtr = (hPtr + 1) % DLY;
    endtask

    initial begin
        for (int k = 0; k < DLY; k++) begin
            hVld[k] = 1'b0;
            hCh[k]  = '0;
            hArg[k] = '0;
        end

        // Reset
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 19'h0, 1'b0, 19'h0);
        tick(1'b0, 2'd0, 20'h0);
        tick(1'b0, 2'd0, 20'h0);
        tick(1'b0, 2'd0, 20'h0);

        // Release, program inc0 with no channel enabled
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 19'h20000, 1'b0, 19'h0);
        tick(1'b0, 2'd0, 20'h0);

        // Single channel issues every cycle, quarter-turn steps, wrap to 0
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 19'h0, 1'b0, 19'h0);
        tick(1'b1, 2'd0, 20'h00000);
        tick(1'b1, 2'd0, 20'h20000);
        tick(1'b1, 2'd0, 20'h40000);
        tick(1'b1, 2'd0, 20'h60000);
        tick(1'b1, 2'd0, 20'h00000);

        // Program ch1: inc 0x100, acc 5
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 19'h00100, 1'b1, 19'h00005);
        tick(1'b0, 2'd0, 20'h00000);

        // Two channels alternate, each advancing every other cycle
        applyStimulus(1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, 2'd0, 19'h0, 1'b0, 19'h0);
        tick(1'b1, 2'd1, 20'h00005);
        tick(1'b1, 2'd0, 20'h20000);
        tick(1'b1, 2'd1, 20'h00105);
        tick(1'b1, 2'd0, 20'h40000);
        tick(1'b1, 2'd1, 20'h00205);
        tick(1'b1, 2'd0, 20'h60000);

        // Program ch3: inc 0x1000, acc 7
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 19'h01000, 1'b1, 19'h00007);
        tick(1'b0, 2'd0, 20'h60000);

        // Channels 1 and 3 interleave, skipping the disabled ones
        applyStimulus(1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, 2'd0, 19'h0, 1'b0, 19'h0);
        tick(1'b1, 2'd1, 20'h00305);
        tick(1'b1, 2'd3, 20'h00007);
        tick(1'b1, 2'd1, 20'h00405);
        tick(1'b1, 2'd3, 20'h01007);

        // All disabled: arg holds, in-flight tags drain and valid falls
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 19'h0, 1'b0, 19'h0);
        for (int n = 0; n < 17; n++) begin
            tick(1'b0, 2'd0, 20'h01007);
        end

        // Config load on ch0 in the same cycle ch0 issues
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 19'h0, 1'b0, 19'h0);
        tick(1'b1, 2'd0, 20'h00000);
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 19'h20000, 1'b1, 19'h10000);
        tick(1'b1, 2'd0, 20'h20000);
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 19'h0, 1'b0, 19'h0);
        tick(1'b1, 2'd0, 20'h10000);
        tick(1'b1, 2'd0, 20'h30000);

        // Sync pulse: bubble, then ch0 restarts from 0
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd0, 19'h0, 1'b0, 19'h0);
        tick(1'b0, 2'd0, 20'h30000);
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 19'h0, 1'b0, 19'h0);
        tick(1'b1, 2'd0, 20'h00000);
        tick(1'b1, 2'd0, 20'h20000);

        // Hold for three cycles: gap, no accumulator advance
        applyStimulus(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 19'h0, 1'b0, 19'h0);
        tick(1'b0, 2'd0, 20'h20000);
        tick(1'b0, 2'd0, 20'h20000);
        tick(1'b0, 2'd0, 20'h20000);
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 19'h0, 1'b0, 19'h0);
        tick(1'b1, 2'd0, 20'h40000);
        tick(1'b1, 2'd0, 20'h60000);

        // ch1 accumulator was also cleared by sync
        applyStimulus(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 19'h0, 1'b0, 19'h0);
        tick(1'b1, 2'd1, 20'h00000);
        tick(1'b1, 2'd1, 20'h00100);

        // Fill the pipe with ten ch0 samples
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 19'h0, 1'b0, 19'h0);
        tick(1'b1, 2'd0, 20'h00000);
        tick(1'b1, 2'd0, 20'h20000);
        tick(1'b1, 2'd0, 20'h40000);
        tick(1'b1, 2'd0, 20'h60000);
        tick(1'b1, 2'd0, 20'h00000);
        tick(1'b1, 2'd0, 20'h20000);
        tick(1'b1, 2'd0, 20'h40000);
        tick(1'b1, 2'd0, 20'h60000);
        tick(1'b1, 2'd0, 20'h00000);
        tick(1'b1, 2'd0, 20'h20000);

        // Reset mid-run drops everything in flight
        applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 19'h0, 1'b0, 19'h0);
        tick(1'b0, 2'd0, 20'h00000);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 19'h20000, 1'b0, 19'h0);
        tick(1'b0, 2'd0, 20'h00000);
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 19'h0, 1'b0, 19'h0);
        tick(1'b1, 2'd0, 20'h00000);
        tick(1'b1, 2'd0, 20'h20000);
        tick(1'b1, 2'd0, 20'h40000);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 19'h0, 1'b0, 19'h0);
        for (int n = 0; n < 17; n++) begin
            tick(1'b0, 2'd0, 20'h40000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
